// File: rtl/instr_loader.sv
// instr_loader: boot-time instruction store writer.
// Packs an MSB-first byte stream into 32-bit words, writes them to the
// instruction memory and holds the CPU in reset until the load completes.
module instr_loader #(
   parameter int DEPTH = 32,
   parameter int LEN_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [7:0]       byte_i,
   input  logic             byte_valid_i,
   output logic             byte_ready_o,
   output logic             wr_en_o,
   output logic [31:0]      wr_addr_o,
   output logic [31:0]      wr_data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             cpu_rst_n_o
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   localparam logic [LEN_W:0]   DEPTH_L = (LEN_W+1)'(DEPTH);
   localparam logic [LEN_W-1:0] IDX_ONE = LEN_W'(1);

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] word_idx;
   logic [1:0]       byte_cnt;
   // Only the three older bytes need storage; the fourth byte goes straight
   // into the write data register on the accepting edge.
   logic [23:0]      shreg;

   logic             len_bad;
   logic             accept;
   logic [LEN_W-1:0] idx_nxt;
   logic [31:0]      shift_nxt;
   logic [31:0]      addr_ext;

   assign len_bad   = (len_i == '0) || ({1'b0, len_i} > DEPTH_L);
   assign accept    = (state == LOAD) && byte_valid_i && byte_ready_o;
   assign idx_nxt   = word_idx + IDX_ONE;
   assign shift_nxt = {shreg, byte_i};
   assign addr_ext  = 32'({word_idx, 2'b00});

   // Load FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         len_q        <= '0;
         word_idx     <= '0;
         byte_cnt     <= '0;
         shreg        <= '0;
         byte_ready_o <= 1'b0;
         wr_en_o      <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         cpu_rst_n_o  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  done_o      <= 1'b0;
                  cpu_rst_n_o <= 1'b0;
                  if (len_bad) begin
                     // Illegal length: flag it and park in IDLE with CPU held.
                     err_o <= 1'b1;
                     state <= IDLE;
                  end else begin
                     len_q        <= len_i;
                     word_idx     <= '0;
                     byte_cnt     <= '0;
                     shreg        <= '0;
                     err_o        <= 1'b0;
                     busy_o       <= 1'b1;
                     byte_ready_o <= 1'b1;
                     state        <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  shreg    <= shift_nxt[23:0];
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     byte_ready_o <= 1'b0;
                     wr_en_o      <= 1'b1;
                     wr_data_o    <= shift_nxt;
                     wr_addr_o    <= addr_ext;
                     state        <= WRITE;
                  end
               end
            end
            WRITE: begin
               wr_en_o  <= 1'b0;
               word_idx <= idx_nxt;
               if (idx_nxt == len_q) begin
                  busy_o      <= 1'b0;
                  done_o      <= 1'b1;
                  cpu_rst_n_o <= 1'b1;
                  state       <= DONE;
               end else begin
                  byte_ready_o <= 1'b1;
                  state        <= LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time writer for the instruction store: accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words, and drives the write port of a writable instruction memory. It holds the processor in reset while loading and releases it once the requested number of words has been written. It sits between the off-chip/test-bench byte source and the instruction memory's write side. The fetch datapath reads the same memory at byte address addr, word index addr/4.

## Interface
Parameters:
- DEPTH, 32, number of 32-bit words in the instruction memory
- LEN_W, 6, width of the word-count input; must be large enough to represent DEPTH

Ports:
- clk_i  input  1  system clock; all state changes on its rising edge
- rst_i  input  1  asynchronous, active-low reset
- start_i  input  1  one-cycle load request; sampled only in IDLE and DONE
- len_i  input  LEN_W  number of words to load; sampled with start_i
- byte_i  input  8  incoming instruction byte
- byte_valid_i  input  1  byte_i is valid
- byte_ready_o  output  1  loader can accept a byte this cycle
- wr_en_o  output  1  one-cycle write strobe to the instruction memory
- wr_addr_o  output  32  byte address of the word being written (word index × 4)
- wr_data_o  output  32  assembled instruction word
- busy_o  output  1  a load is in progress
- done_o  output  1  the last load completed successfully
- err_o  output  1  the last start_i carried an illegal len_i
- cpu_rst_n_o  output  1  active-low reset to the processor; 0 holds the CPU in reset

## Operation
- States:
  - IDLE: reset state.
  - LOAD: collecting bytes.
  - WRITE: issuing one write strobe.
  - DONE: load finished; CPU running.
- IDLE/DONE + start_i:
  - If len_i == 0 or len_i > DEPTH: set err_o=1, clear done_o, drop cpu_rst_n_o to 0, go to IDLE.
  - Otherwise: latch len_i, clear word index, byte count, err_o and done_o; set cpu_rst_n_o=0; go to LOAD.
- start_i in LOAD/WRITE is ignored.
- LOAD:
  - byte_ready_o=1. A byte transfers when byte_valid_i && byte_ready_o.
  - Bytes arrive MSB first: the 1st byte lands in [31:24], the 4th in [7:0]. The shift register shifts left by 8 per accepted byte.
  - On acceptance of the 4th byte, go to WRITE.
- WRITE:
  - byte_ready_o=0.
  - wr_en_o=1, wr_data_o = assembled word, wr_addr_o = {word_index, 2'b00} zero-extended to 32 bits.
  - Next cycle: increment word_index. If word_index+1 == latched len, go to DONE; otherwise go to LOAD.
- DONE: done_o=1, cpu_rst_n_o=1, busy_o=0, byte_ready_o=0. Stays in DONE until reset or start_i.
- busy_o=1 exactly in LOAD and WRITE.
- byte_valid_i is ignored whenever byte_ready_o=0; bytes are never dropped or double-counted.
- wr_addr_o and wr_data_o hold their last written value outside WRITE.
- Asynchronous reset asserted at any time (including mid-word or mid-WRITE) forces IDLE and discards the partial word. The memory keeps any words already written; the loader does not erase them.

## Timing
- Reset values: byte_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, err_o=0, cpu_rst_n_o=0. Internal word index, byte count and shift register are all 0.
- start_i at edge N → LOAD during cycle N+1; byte_ready_o=1 from cycle N+1.
- Accepting the 4th byte at edge M → wr_en_o=1 during cycle M+1 only.
  - Not the last word: byte_ready_o returns to 1 in cycle M+2.
  - Last word: done_o=1 and cpu_rst_n_o=1 from cycle M+2.
- Minimum time per word is 5 cycles (4 accept cycles + 1 WRITE cycle). A full DEPTH=32 load takes at least 160 cycles after start.
- err_o is asserted the cycle after the bad start_i. It stays set until the next legal start_i or reset.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then len_i=1, bytes 0x20,0x08,0x00,0x05 streamed back-to-back → one wr_en_o pulse with wr_addr_o=0x0 and wr_data_o=0x20080005; done_o=1 and cpu_rst_n_o=1 two cycles after the 4th byte.
- len_i=32, continuous valid bytes encoding word k as 0xA5000000+k → 32 strobes at addresses 0x00..0x7C with matching data; byte_ready_o low exactly in each WRITE cycle; done_o asserts after the 32nd strobe.
- len_i=2, byte_valid_i toggled randomly 50% → same two words written at 0x0 and 0x4; no extra or missing strobes.
- start_i with len_i=0, then with len_i=33 → err_o=1, no wr_en_o, cpu_rst_n_o=0. A following start_i with len_i=1 clears err_o.
- Reset asserted after 2 bytes of word 1 of a 3-word load → all outputs at reset values asynchronously. A fresh len_i=1 load writes address 0x0 with 4 new bytes, not the stale partial data.
- start_i pulsed during LOAD → ignored (len and index unchanged). start_i in DONE with len_i=1 → cpu_rst_n_o drops to 0, done_o clears, and a new load begins at address 0x0.
